// File: rtl/cq_viola_nios2_s_cpu_div_cell_if.sv
// Operand/result bundle between the E-stage and the divide cell.
// Handshake: div_start is a request accepted on a rising edge only while the
// cell is idle (div_busy low) and div_abort is low; div_done pulses for one
// cycle when div_quot/div_rem/div_by_zero become valid; div_abort cancels any
// operation in flight without producing div_done.
interface cq_viola_nios2_s_cpu_div_cell_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] E_src1;
  logic [WIDTH-1:0] E_src2;
  logic             div_start;
  logic             div_signed;
  logic             div_abort;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;
  logic             div_by_zero;

  // Pipeline side: drives operands and control, observes results.
  modport master (
    output E_src1, E_src2, div_start, div_signed, div_abort,
    input  div_busy, div_done, div_quot, div_rem, div_by_zero
  );

  // Divider side.
  modport slave (
    input  E_src1, E_src2, div_start, div_signed, div_abort,
    output div_busy, div_done, div_quot, div_rem, div_by_zero
  );
endinterface

// File: rtl/cq_viola_nios2_s_cpu_div_cell.sv
// Iterative radix-2 restoring divider (signed and unsigned), one quotient bit
// per clock. Latency is WIDTH+2 clocks from the accepting edge.
// Optional feature macro: CQ_VIOLA_DIV_EARLY_OUT_EN -- when defined, operations
// with |dividend| < |divisor| (divisor non-zero) skip the iteration phase and
// complete 2 clocks after acceptance with quot=0, rem=dividend.
// div_state exposes the FSM state (0=IDLE, 1=PREP, 2=ITER, 3=FIX).
module cq_viola_nios2_s_cpu_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                reset_n,
  cq_viola_nios2_s_cpu_div_cell_if.slave      bus,
  output logic [1:0]                          div_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  // Working registers: dvd_r holds the dividend, then shifts quotient bits in
  // from the LSB as dividend bits shift out of the MSB into the remainder.
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] rem_r;
  logic             sgn_r;
  logic             quot_neg;
  logic             rem_neg;
  logic             by_zero_r;
  logic [CW-1:0]    cnt;

  // Held results.
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             by_zero_q;
  logic             done_q;

  logic             accept;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             early_out;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;

  assign accept = (state == IDLE) && bus.div_start && !bus.div_abort;

  // Magnitudes are only meaningful in PREP, where dvd_r/dvs_r still hold the
  // raw latched operands. -x of the most-negative value wraps to itself, which
  // reads correctly as an unsigned magnitude.
  assign mag1 = (sgn_r && dvd_r[WIDTH-1]) ? -dvd_r : dvd_r;
  assign mag2 = (sgn_r && dvs_r[WIDTH-1]) ? -dvs_r : dvs_r;

`ifdef CQ_VIOLA_DIV_EARLY_OUT_EN
  assign early_out = (mag1 < mag2) && (mag2 != '0);
`else
  assign early_out = 1'b0;
`endif

  // Restoring step: trial subtract on WIDTH+1 bits; a clear sign bit means
  // the shifted remainder was >= divisor.
  assign shifted = {rem_r, dvd_r[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_r};
  assign q_bit   = ~trial[WIDTH];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; abort from any active state returns straight to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = PREP;
      PREP: state_nx = early_out ? FIX : ITER;
      ITER: if (cnt == CW'(1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if ((state != IDLE) && bus.div_abort) state_nx = IDLE;
  end

  // Datapath: operand latch, sign/magnitude prep, iteration and final fix-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvd_r     <= '0;
      dvs_r     <= '0;
      rem_r     <= '0;
      sgn_r     <= 1'b0;
      quot_neg  <= 1'b0;
      rem_neg   <= 1'b0;
      by_zero_r <= 1'b0;
      cnt       <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      by_zero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dvd_r <= bus.E_src1;
            dvs_r <= bus.E_src2;
            sgn_r <= bus.div_signed;
          end
        end
        PREP: begin
          quot_neg  <= sgn_r & (dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1]);
          rem_neg   <= sgn_r & dvd_r[WIDTH-1];
          by_zero_r <= (dvs_r == '0);
          dvs_r     <= mag2;
          cnt       <= CW'(WIDTH);
          if (early_out) begin
            rem_r <= mag1;
            dvd_r <= '0;
          end else begin
            rem_r <= '0;
            dvd_r <= mag1;
          end
        end
        ITER: begin
          rem_r <= q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          dvd_r <= {dvd_r[WIDTH-2:0], q_bit};
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          // Divide by zero leaves |dividend| in rem_r, so the remainder sign
          // fix restores the original dividend; the quotient is forced.
          if (!bus.div_abort) begin
            quot_q    <= by_zero_r ? '1 : (quot_neg ? -dvd_r : dvd_r);
            rem_q     <= rem_neg ? -rem_r : rem_r;
            by_zero_q <= by_zero_r;
            done_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.div_busy    = (state != IDLE);
  assign bus.div_done    = done_q;
  assign bus.div_quot    = quot_q;
  assign bus.div_rem     = rem_q;
  assign bus.div_by_zero = by_zero_q;
  assign div_state       = state;

endmodule

// File: tb/tb_cq_viola_nios2_s_cpu_div_cell.sv
// Self-checking bench for the divide cell: directed corner cases plus random
// signed/unsigned operations, checked through an expected-result queue.
module tb_cq_viola_nios2_s_cpu_div_cell;
  localparam int W = 32;

  typedef logic [2*W:0] res_t;   // {by_zero, quot, rem}

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cq_viola_nios2_s_cpu_div_cell_if #(.WIDTH(W)) bus ();
  logic [1:0] dbg_state;

  cq_viola_nios2_s_cpu_div_cell #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (rst_n),
    .bus       (bus),
    .div_state (dbg_state)
  );

  // Scoreboard state
  res_t exp_q[$];
  int   lat_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_seen = 0;
  res_t last_res = '0;

  always @(negedge clk) if (bus.div_done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model from the arithmetic definition of div/divu.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic [W-1:0] q;
    logic [W-1:0] r;
    sa = a;
    sb = b;
    if (b == '0) begin
      return {1'b1, {W{1'b1}}, a};
    end else if (sgn && a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) begin
      return {1'b0, a, {W{1'b0}}};
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    ma = (sgn && a[W-1]) ? -a : a;
    mb = (sgn && b[W-1]) ? -b : b;
`ifdef CQ_VIOLA_DIV_EARLY_OUT_EN
    if (mb != '0 && ma < mb) return 2;
`endif
    return W + 2;
  endfunction

  // Driver: presents a start request so that the next rising edge accepts it.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    bus.E_src1     = a;
    bus.E_src2     = b;
    bus.div_signed = sgn;
    bus.div_start  = 1'b1;
    @(posedge clk);
    #1;
    bus.div_start  = 1'b0;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    exp_q.push_back(model(a, b, sgn));
    lat_q.push_back(model_lat(a, b, sgn));
    drive_start(a, b, sgn);
  endtask

  // Waits (bounded) for div_done after an issue; optionally pokes stray starts.
  task automatic wait_done(input string tag, input bit poke);
    int   n;
    int   busy_low;
    int   d0;
    bit   got;
    res_t e;
    int   l;
    n = 0; busy_low = 0; got = 0; d0 = done_seen;
    while (n < 100 && !got) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.div_done === 1'b1) got = 1;
      else if (bus.div_busy !== 1'b1) busy_low++;
      if (poke && !got) begin
        bus.div_start = (n == 5 || n == 20);
        bus.E_src1    = $urandom;
        bus.E_src2    = $urandom;
      end
    end
    bus.div_start = 1'b0;
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 64'(n), 64'(l));
      return;
    end
    check({tag, "_lat"},  64'(n), 64'(l));
    check({tag, "_quot"}, 64'(bus.div_quot), 64'(e[2*W-1:W]));
    check({tag, "_rem"},  64'(bus.div_rem),  64'(e[W-1:0]));
    check({tag, "_dbz"},  64'(bus.div_by_zero), 64'(e[2*W]));
    check({tag, "_busy_gap"}, 64'(busy_low), 64'd0);
    check({tag, "_busy_at_done"}, 64'(bus.div_busy), 64'd0);
    last_res = e;
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_done_count"}, 64'(done_seen - d0), 64'd1);
    end
  endtask

  initial begin
    int d0;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    bus.E_src1 = '0; bus.E_src2 = '0; bus.div_start = 1'b0;
    bus.div_signed = 1'b0; bus.div_abort = 1'b0;

    // Reset
    #2 rst_n = 1'b0;
    #10;
    check("rst_busy", 64'(bus.div_busy), 64'd0);
    check("rst_done", 64'(bus.div_done), 64'd0);
    check("rst_quot", 64'(bus.div_quot), 64'd0);
    check("rst_rem",  64'(bus.div_rem),  64'd0);
    check("rst_dbz",  64'(bus.div_by_zero), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    issue(32'd100, 32'd7, 1'b0);                 wait_done("u100_7", 0);
    issue(-32'sd100, 32'd7, 1'b1);               wait_done("sm100_7", 0);
    issue(32'd100, -32'sd7, 1'b1);               wait_done("s100_m7", 0);
    issue(32'd5, 32'd0, 1'b0);                   wait_done("u5_0", 0);
    issue(-32'sd5, 32'd0, 1'b1);                 wait_done("sm5_0", 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);   wait_done("s_ovf", 0);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);           wait_done("u_max_1", 0);
    issue(32'd3, 32'd10, 1'b0);                  wait_done("u3_10", 0);

    // Abort mid-operation: no done, held results unchanged
    drive_start(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1 bus.div_abort = 1'b1;
    @(posedge clk);
    #1 bus.div_abort = 1'b0;
    check("abort_busy", 64'(bus.div_busy), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    d0 = done_seen;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_seen - d0), 64'd0);
    check("abort_hold_quot", 64'(bus.div_quot), 64'(last_res[2*W-1:W]));
    check("abort_hold_rem",  64'(bus.div_rem),  64'(last_res[W-1:0]));
    issue(32'd9, 32'd3, 1'b0);                   wait_done("after_abort", 0);

    // Stray starts while busy
    issue(32'd1000, 32'd13, 1'b0);               wait_done("poke", 1);

    // Abort and start together in IDLE: start dropped
    d0 = done_seen;
    bus.E_src1 = 32'd50; bus.E_src2 = 32'd5; bus.div_signed = 1'b0;
    bus.div_start = 1'b1; bus.div_abort = 1'b1;
    @(posedge clk);
    #1 bus.div_start = 1'b0; bus.div_abort = 1'b0;
    check("abort_start_busy", 64'(bus.div_busy), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_start_no_done", 64'(done_seen - d0), 64'd0);

    // Asynchronous reset during an operation
    drive_start(32'd100, 32'd7, 1'b0);
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.div_busy), 64'd0);
    check("mid_rst_quot", 64'(bus.div_quot), 64'd0);
    check("mid_rst_rem",  64'(bus.div_rem),  64'd0);
    check("mid_rst_dbz",  64'(bus.div_by_zero), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    d0 = done_seen;
    repeat (40) @(posedge clk);
    #1;
    check("mid_rst_no_done", 64'(done_seen - d0), 64'd0);

    // Random operations
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: b = W'($urandom_range(1, 15));
        1: b = $urandom;
        2: b = (i % 4 == 0) ? '0 : W'($urandom_range(1, 300));
        default: begin a = W'($urandom_range(0, 50)); b = W'($urandom_range(51, 1000)); end
      endcase
      issue(a, b, s);
      wait_done("rand", 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
